// File: rtl/psum_drain_requant_pkg.sv
// Shared types and default widths for the psum drain/requantize datapath.
package psum_drain_requant_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH   = 8;
  localparam int DEF_CNT_WIDTH   = 4;
  localparam int DEF_SHIFT_WIDTH = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_DRAIN = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } drain_state_e;

endpackage

// File: rtl/psum_drain_requant_requant.sv
// Combinational requantizer: bias add, rounding arithmetic shift, optional ReLU, signed saturation.
module psum_requant
  import psum_drain_requant_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [DATA_WIDTH-1:0]  bias_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  input  logic                   relu_en_i,
  output logic [OUT_WIDTH-1:0]   result_o
);

  localparam int W = DATA_WIDTH + 2;
  localparam logic signed [W-1:0] SatMax = W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [W-1:0] SatMin = -SatMax - W'(1);

  logic signed [W-1:0] sum;
  logic signed [W-1:0] rounded;
  logic signed [W-1:0] shifted;
  logic signed [W-1:0] clamped;

  // Two guard bits keep data+bias+rounding term from overflowing before the shift.
  always_comb begin
    sum     = {{2{data_i[DATA_WIDTH-1]}}, data_i} + {{2{bias_i[DATA_WIDTH-1]}}, bias_i};
    rounded = sum;
    shifted = sum;
    if (shift_i != '0) begin
      if (32'(shift_i) >= DATA_WIDTH) begin
        shifted = {W{sum[W-1]}};
      end else begin
        rounded = sum + (W'(1) << (shift_i - SHIFT_WIDTH'(1)));
        shifted = rounded >>> shift_i;
      end
    end
    clamped = shifted;
    if (relu_en_i && shifted < 0) begin
      clamped = '0;
    end else if (shifted > SatMax) begin
      clamped = SatMax;
    end else if (shifted < SatMin) begin
      clamped = SatMin;
    end
    result_o = clamped[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/psum_drain_requant.sv
// Drains the accumulation FIFO, requantizes each psum and streams results out over valid/ready.
module psum_drain_requant
  import psum_drain_requant_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   num_words,
  input  logic [DATA_WIDTH-1:0]  bias,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   relu_en,
  output logic                   fifo_rd_clr,
  output logic                   fifo_rd_en,
  output logic                   fifo_rd_inc,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  drain_state_e            state_q;
  logic                    clr_q, done_q, busy_q, inflight_q;
  logic [CNT_WIDTH-1:0]    num_q, issued_q;
  logic [DATA_WIDTH-1:0]   bias_q;
  logic [SHIFT_WIDTH-1:0]  shift_q;
  logic                    relu_q;

  logic [OUT_WIDTH-1:0]    buf_q [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              count_q;
  logic                    push, pop;
  logic [2:0]              occupancy;
  logic [OUT_WIDTH-1:0]    req_result;

  psum_requant #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_requant (
    .data_i   (fifo_data),
    .bias_i   (bias_q),
    .shift_i  (shift_q),
    .relu_en_i(relu_q),
    .result_o (req_result)
  );

  assign push = inflight_q;
  assign pop  = out_valid && out_ready;
  // Slot freed by this cycle's pop counts as credit so a ready consumer sees one word per cycle.
  assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en  = (state_q == S_DRAIN) && (occupancy < 3'd2);
  assign fifo_rd_inc = fifo_rd_en;
  assign fifo_rd_clr = clr_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = buf_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      inflight_q <= 1'b0;
      num_q      <= '0;
      issued_q   <= '0;
      bias_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
    end else begin
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= fifo_rd_en;
      unique case (state_q)
        S_IDLE: if (start) begin
          num_q    <= num_words;
          bias_q   <= bias;
          shift_q  <= shift;
          relu_q   <= relu_en;
          issued_q <= '0;
          clr_q    <= 1'b1;
          busy_q   <= 1'b1;
          state_q  <= S_CLR;
        end
        S_CLR: if (num_q == '0) begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end else begin
          state_q <= S_DRAIN;
        end
        S_DRAIN: if (fifo_rd_en) begin
          issued_q <= issued_q + CntOne;
          if (issued_q + CntOne == num_q) state_q <= S_FLUSH;
        end
        S_FLUSH: if (!inflight_q && count_q == 2'd0) begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= req_result;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_psum_drain_requant.sv
// Bench for psum_drain_requant: directed table, randomized drains vs. arithmetic model, reset/busy corners.
module tb_psum_drain_requant;

  localparam int DW = 16;
  localparam int OW = 8;
  localparam int CW = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] numWords = '0;
  logic [DW-1:0] bias = '0;
  logic [SW-1:0] shift = '0;
  logic          reluEn = 1'b0;
  logic          fifoRdClr, fifoRdEn, fifoRdInc;
  logic [DW-1:0] fifoData;
  logic [OW-1:0] outData;
  logic          outValid;
  logic          outReady = 1'b0;
  logic          busy, done;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] mem [16];
  logic [CW-1:0] rptr;
  int            expQ [$];

  typedef struct {
    string tag;
    int    d0, d1, d2;
    int    b, s;
    bit    r;
    int    e0, e1, e2;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  psum_drain_requant dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (numWords),
    .bias       (bias),
    .shift      (shift),
    .relu_en    (reluEn),
    .fifo_rd_clr(fifoRdClr),
    .fifo_rd_en (fifoRdEn),
    .fifo_rd_inc(fifoRdInc),
    .fifo_data  (fifoData),
    .out_data   (outData),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .busy       (busy),
    .done       (done)
  );

  // FIFO read side with one cycle of read latency; data reads as zero when not requested.
  always @(posedge clk) begin
    if (fifoRdClr) rptr <= '0;
    else if (fifoRdEn) rptr <= rptr + 1'b1;
    fifoData <= fifoRdEn ? mem[rptr] : '0;
  end

  function automatic int requantRef(input int d, input int b, input int s, input bit r);
    int v;
    v = d + b;
    if (s > 0) v = (v + (1 << (s - 1))) >>> s;
    if (r && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int n, input int b, input int s, input bit r);
    start    = 1'b1;
    numWords = CW'(n);
    bias     = DW'(b);
    shift    = SW'(s);
    reluEn   = r;
  endtask

  task automatic buildExpected(input int n, input int b, input int s, input bit r);
    expQ.delete();
    for (int i = 0; i < n; i++) expQ.push_back(requantRef(int'($signed(mem[i])), b, s, r));
  endtask

  task automatic runDrain(input string tag, input int n, input int b, input int s, input bit r,
                          input int mode, input int busyStartAt,
                          output int firstRd, output int firstValid, output int lastValid,
                          output int doneCycle);
    int issued, accepted, doneCnt, clrCnt, clrCycle;
    bit prevStall;
    logic [OW-1:0] prevData;
    issued = 0; accepted = 0; doneCnt = 0; clrCnt = 0; clrCycle = -1;
    firstRd = -1; firstValid = -1; lastValid = -1; doneCycle = -1;
    prevStall = 1'b0; prevData = '0;
    @(negedge clk);
    applyStimulus(n, b, s, r);
    for (int cyc = 1; cyc <= 40 + 8 * n && doneCnt == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == busyStartAt) applyStimulus(1, 999, 0, !r);
      case (mode)
        0:       outReady = 1'b1;
        1:       outReady = (cyc % 4 == 0);
        default: outReady = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 1) checkOutput({tag, "_busy"}, int'(busy), 1);
      if (prevStall) begin
        checkOutput({tag, "_hold_valid"}, int'(outValid), 1);
        checkOutput({tag, "_hold_data"}, int'(outData), int'(prevData));
      end
      if (fifoRdClr) begin clrCnt++; clrCycle = cyc; end
      if (fifoRdEn) begin
        issued++;
        if (firstRd < 0) firstRd = cyc;
        checkOutput({tag, "_rd_inc"}, int'(fifoRdInc), 1);
      end
      if (outValid && outReady) begin
        if (firstValid < 0) firstValid = cyc;
        lastValid = cyc;
        if (accepted < expQ.size())
          checkOutput($sformatf("%s_out%0d", tag, accepted), int'($signed(outData)), expQ[accepted]);
        else
          checkOutput({tag, "_extra_out"}, accepted, expQ.size() - 1);
        accepted++;
      end
      if (fifoRdEn) checkOutput({tag, "_credit"}, int'((issued - accepted) <= 2), 1);
      prevStall = outValid && !outReady;
      prevData  = outData;
      if (done) begin doneCnt++; doneCycle = cyc; end
    end
    if (doneCnt == 0) checkOutput({tag, "_timeout"}, 0, 1);
    checkOutput({tag, "_accepted"}, accepted, n);
    checkOutput({tag, "_issued"}, issued, n);
    checkOutput({tag, "_clr_cnt"}, clrCnt, 1);
    checkOutput({tag, "_clr_cycle"}, clrCycle, 1);
    @(negedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, int'(done), 0);
    checkOutput({tag, "_busy_end"}, int'(busy), 0);
    outReady = 1'b0;
  endtask

  initial begin
    int fr, fv, lv, dc, issued, n, b, s;
    bit r;

    vecs[0] = '{"basic",    100, -300, 5,   0, 2, 1'b0, 25,  -75, 1};
    vecs[1] = '{"saturate", 1000, -1000, 127, 0, 0, 1'b0, 127, -128, 127};
    vecs[2] = '{"relu",     100, -300, 5,   4, 2, 1'b1, 26,  0,   2};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_rd_clr", int'(fifoRdClr), 0);
    checkOutput("rst_rd_en", int'(fifoRdEn), 0);
    checkOutput("rst_out_valid", int'(outValid), 0);
    checkOutput("rst_out_data", int'(outData), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      mem[0] = DW'(vecs[v].d0); mem[1] = DW'(vecs[v].d1); mem[2] = DW'(vecs[v].d2);
      expQ.delete();
      expQ.push_back(vecs[v].e0); expQ.push_back(vecs[v].e1); expQ.push_back(vecs[v].e2);
      runDrain(vecs[v].tag, 3, vecs[v].b, vecs[v].s, vecs[v].r, 0, -1, fr, fv, lv, dc);
      checkOutput({vecs[v].tag, "_latency"}, fv - fr, 2);
      checkOutput({vecs[v].tag, "_back2back"}, lv - fv, 2);
    end

    // Heavy backpressure: one accept every four cycles.
    for (int i = 0; i < 5; i++) mem[i] = DW'(i * 37 - 80);
    buildExpected(5, 3, 1, 1'b0);
    runDrain("bp", 5, 3, 1, 1'b0, 1, -1, fr, fv, lv, dc);

    // Empty drain: clear pulse only, done two cycles after start.
    expQ.delete();
    runDrain("zero", 0, 0, 0, 1'b0, 0, -1, fr, fv, lv, dc);
    checkOutput("zero_done_cycle", dc, 2);
    checkOutput("zero_no_rd", fr, -1);

    // Start while busy must leave the running drain untouched.
    for (int i = 0; i < 5; i++) mem[i] = DW'(i * 500 - 900);
    buildExpected(5, -20, 3, 1'b0);
    runDrain("busy_start", 5, -20, 3, 1'b0, 0, 3, fr, fv, lv, dc);

    // Full-depth drain with maximum shift.
    for (int i = 0; i < 15; i++) mem[i] = DW'($urandom);
    buildExpected(15, 1234, 15, 1'b0);
    runDrain("max_n", 15, 1234, 15, 1'b0, 2, -1, fr, fv, lv, dc);

    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 15);
      b = int'($signed(DW'($urandom)));
      s = $urandom_range(0, 15);
      r = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
      buildExpected(n, b, s, r);
      runDrain($sformatf("rand%0d", k), n, b, s, r, $urandom_range(0, 2), -1, fr, fv, lv, dc);
    end

    // Reset in the middle of a drain, then a fresh drain must restart from address 0.
    for (int i = 0; i < 5; i++) mem[i] = DW'(i * 61 - 50);
    issued = 0;
    @(negedge clk);
    applyStimulus(5, 0, 0, 1'b0);
    outReady = 1'b0;
    for (int cyc = 0; cyc < 12 && issued < 2; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (fifoRdEn) issued++;
    end
    checkOutput("mid_rst_issued", issued, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mid_rst_rd_clr", int'(fifoRdClr), 0);
    checkOutput("mid_rst_rd_en", int'(fifoRdEn), 0);
    checkOutput("mid_rst_rd_inc", int'(fifoRdInc), 0);
    checkOutput("mid_rst_out_valid", int'(outValid), 0);
    checkOutput("mid_rst_out_data", int'(outData), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_done", int'(done), 0);
    rst = 1'b0;
    buildExpected(3, 7, 1, 1'b1);
    runDrain("post_rst", 3, 7, 1, 1'b1, 0, -1, fr, fv, lv, dc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
